// File: rtl/eth10g_link_led_ctrl_if.sv
// Signal bundle between the 10G MAC/PCS status sources and the link/activity
// LED engine.
//
// Ports grouped here:
//   link_up_raw   per-channel raw link level, asynchronous to the system clock
//   rx_act/tx_act per-channel single-cycle frame strobes, system-clock domain
//   led_mode      0 = per-channel display, 1 = aggregate display
//   drop_cnt_clr  single-cycle strobe clearing every drop counter
//   sleds         registered LED drive, 1 = lit
//   link_stable   debounced link state per channel
//   link_drop_cnt 8-bit saturating drop counter per channel, channel i at [8i+7:8i]
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// strobe (rx_act, tx_act, drop_cnt_clr) is a one-cycle qualifier sampled on
// the rising system clock edge and is always accepted; levels (link_up_raw,
// led_mode) are sampled every cycle.
interface eth10g_link_led_ctrl_if #(
    parameter int SFP_COUNT = 2,
    parameter int LED_COUNT = 4
) ();
    logic [SFP_COUNT-1:0]   link_up_raw;
    logic [SFP_COUNT-1:0]   rx_act;
    logic [SFP_COUNT-1:0]   tx_act;
    logic                   led_mode;
    logic                   drop_cnt_clr;
    logic [LED_COUNT-1:0]   sleds;
    logic [SFP_COUNT-1:0]   link_stable;
    logic [8*SFP_COUNT-1:0] link_drop_cnt;

    // Status source / board side.
    modport master (
        output link_up_raw, rx_act, tx_act, led_mode, drop_cnt_clr,
        input  sleds, link_stable, link_drop_cnt
    );

    // LED engine side.
    modport slave (
        input  link_up_raw, rx_act, tx_act, led_mode, drop_cnt_clr,
        output sleds, link_stable, link_drop_cnt
    );
endinterface

// File: rtl/eth10g_link_led_ctrl.sv
// Link/activity status engine for the multi-SFP 10G Ethernet test top.
// Synchronises and debounces per-channel link levels, stretches rx/tx frame
// strobes into blinking activity, counts link drops and drives an LED bank
// in either a per-channel or an aggregate display mode.
//
// Ports:
//   sysclk_100m  system clock, the only clock in the block
//   sys_reset    synchronous active-high reset
//   bus          eth10g_link_led_ctrl_if.slave (see the interface header)
//
// The interface instance must be built with the same SFP_COUNT/LED_COUNT as
// this module.
module eth10g_link_led_ctrl #(
    parameter int SFP_COUNT = 2,
    parameter int LED_COUNT = 4,
    parameter int DEBOUNCE  = 1000000,
    parameter int ACT_HOLD  = 5000000,
    parameter int BLINK_DIV = 5000000,
    parameter int HB_DIV    = 50000000
) (
    input logic                  sysclk_100m,
    input logic                  sys_reset,
    eth10g_link_led_ctrl_if.slave bus
);
    localparam int N    = (SFP_COUNT < LED_COUNT) ? SFP_COUNT : LED_COUNT;
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int AH_W = $clog2(ACT_HOLD + 1);
    localparam int BD_W = $clog2(BLINK_DIV + 1);
    localparam int HB_W = $clog2(HB_DIV + 1);

    logic [SFP_COUNT-1:0]           sync1;
    logic [SFP_COUNT-1:0]           link_sync;
    logic [SFP_COUNT-1:0]           stable_q;
    logic [SFP_COUNT-1:0][DB_W-1:0] db_cnt;
    logic [SFP_COUNT-1:0][AH_W-1:0] act_cnt;
    logic [SFP_COUNT-1:0][7:0]      drop_cnt;
    logic [BD_W-1:0]                blink_div;
    logic                           blink_phase;
    logic [HB_W-1:0]                hb_div;
    logic                           hb_phase;
    logic [LED_COUNT-1:0]           sleds_q;

    logic [SFP_COUNT-1:0] act;
    logic [SFP_COUNT-1:0] db_done;
    logic [SFP_COUNT-1:0] drop_evt;
    logic [SFP_COUNT-1:0] active;
    logic                 all_up;
    logic                 any_active;
    logic                 any_drop;
    logic [LED_COUNT-1:0] led_next;

    assign act        = bus.rx_act | bus.tx_act;
    assign all_up     = &stable_q;
    assign any_active = |active;

    always_comb begin
        db_done  = '0;
        drop_evt = '0;
        active   = '0;
        any_drop = 1'b0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            // The debounce window has elapsed with the levels still disagreeing.
            db_done[i]  = (link_sync[i] != stable_q[i]) && (db_cnt[i] == DB_W'(DEBOUNCE - 1));
            // A completed debounce while currently up is a 1->0 transition.
            drop_evt[i] = db_done[i] & stable_q[i];
            active[i]   = (act_cnt[i] != '0);
            any_drop    = any_drop | (drop_cnt[i] != 8'd0);
        end
    end

    // LED image for the next edge; sleds_q registers it.
    always_comb begin
        led_next = '0;
        if (!bus.led_mode) begin
            for (int i = 0; i < N; i++) begin
                led_next[i] = stable_q[i] & (active[i] ? blink_phase : 1'b1);
            end
            // Spare LEDs beyond the channel count: top one is the heartbeat,
            // the rest show "all links up". Loop is empty if there are none.
            for (int i = SFP_COUNT; i < LED_COUNT; i++) begin
                led_next[i] = (i == LED_COUNT - 1) ? hb_phase : all_up;
            end
        end else begin
            led_next[0] = all_up;
            for (int i = 1; i < LED_COUNT; i++) begin
                if (i == 1) begin
                    led_next[i] = any_active & blink_phase;
                end else if (i == 2) begin
                    led_next[i] = any_drop;
                end else if (i == LED_COUNT - 1) begin
                    led_next[i] = hb_phase;
                end
            end
        end
    end

    always_ff @(posedge sysclk_100m) begin
        if (sys_reset) begin
            sync1       <= '0;
            link_sync   <= '0;
            stable_q    <= '0;
            db_cnt      <= '0;
            act_cnt     <= '0;
            drop_cnt    <= '0;
            blink_div   <= '0;
            blink_phase <= 1'b0;
            hb_div      <= '0;
            hb_phase    <= 1'b0;
            sleds_q     <= '0;
        end else begin
            sync1     <= bus.link_up_raw;
            link_sync <= sync1;

            for (int i = 0; i < SFP_COUNT; i++) begin
                // Debounce: any agreeing cycle restarts the window.
                if (link_sync[i] == stable_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_done[i]) begin
                    db_cnt[i]   <= '0;
                    stable_q[i] <= link_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end

                // A clear coinciding with a drop keeps the drop.
                if (bus.drop_cnt_clr) begin
                    drop_cnt[i] <= {7'd0, drop_evt[i]};
                end else if (drop_evt[i] && (drop_cnt[i] != 8'hFF)) begin
                    drop_cnt[i] <= drop_cnt[i] + 8'd1;
                end

                // Activity stretch, suppressed entirely while the link is down.
                if (!stable_q[i]) begin
                    act_cnt[i] <= '0;
                end else if (act[i]) begin
                    act_cnt[i] <= AH_W'(ACT_HOLD);
                end else if (active[i]) begin
                    act_cnt[i] <= act_cnt[i] - 1'b1;
                end
            end

            if (blink_div == BD_W'(BLINK_DIV - 1)) begin
                blink_div   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_div <= blink_div + 1'b1;
            end

            if (hb_div == HB_W'(HB_DIV - 1)) begin
                hb_div   <= '0;
                hb_phase <= ~hb_phase;
            end else begin
                hb_div <= hb_div + 1'b1;
            end

            sleds_q <= led_next;
        end
    end

    assign bus.sleds         = sleds_q;
    assign bus.link_stable   = stable_q;
    assign bus.link_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_eth10g_link_led_ctrl.sv
// Directed bench for eth10g_link_led_ctrl with SFP_COUNT=2, LED_COUNT=4,
// DEBOUNCE=4, ACT_HOLD=20, BLINK_DIV=8, HB_DIV=16. A free cycle count since
// reset release (cyc) gives the expected blink/heartbeat phases: after k
// post-reset edges the phase registers hold (k/8)%2 and (k/16)%2, so the
// registered LEDs after edge k show the values for k-1.
module tb_eth10g_link_led_ctrl;
    localparam int SFP = 2;
    localparam int LED = 4;

    logic clk;
    logic sys_reset;
    int   cyc;
    int   total;
    int   bad;

    eth10g_link_led_ctrl_if #(.SFP_COUNT(SFP), .LED_COUNT(LED)) bus ();

    eth10g_link_led_ctrl #(
        .SFP_COUNT(SFP), .LED_COUNT(LED), .DEBOUNCE(4),
        .ACT_HOLD(20), .BLINK_DIV(8), .HB_DIV(16)
    ) dut (
        .sysclk_100m(clk),
        .sys_reset  (sys_reset),
        .bus        (bus)
    );

    // Clock / reset-relative cycle count.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sys_reset) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    // Driver helper: advance n edges, land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic hb_led(input int k);
        return (((k - 1) / 16) % 2) == 1;
    endfunction

    function automatic logic blink_led(input int k);
        return (((k - 1) / 8) % 2) == 1;
    endfunction

    task automatic test_reset();
        logic [3:0] exp;
        sys_reset        = 1'b1;
        bus.link_up_raw  = '0;
        bus.rx_act       = '0;
        bus.tx_act       = '0;
        bus.led_mode     = 1'b0;
        bus.drop_cnt_clr = 1'b0;
        tick(3);
        total++; if (bus.sleds !== 4'b0000) begin bad++; $display("FAIL reset_sleds: got %b want 0000", bus.sleds); end
        total++; if (bus.link_stable !== 2'b00) begin bad++; $display("FAIL reset_stable: got %b want 00", bus.link_stable); end
        total++; if (bus.link_drop_cnt !== 16'h0000) begin bad++; $display("FAIL reset_drop: got %h want 0000", bus.link_drop_cnt); end
        sys_reset = 1'b0;
        // Heartbeat LED: 0 through edge 16, 1 from edge 17, 0 again from 33.
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            exp = {hb_led(cyc), 3'b000};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL hb_after_reset edge %0d: got %b want %b", cyc, bus.sleds, exp); end
        end
    endtask

    task automatic test_debounce();
        logic [1:0] exp_st;
        logic [3:0] exp;
        bus.link_up_raw = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_st = {1'b0, (k >= 6)};
            total++; if (bus.link_stable !== exp_st) begin bad++; $display("FAIL debounce_rise edge %0d: got %b want %b", k, bus.link_stable, exp_st); end
        end
        total++; if (bus.sleds[0] !== 1'b0) begin bad++; $display("FAIL led0_lag: got %b want 0", bus.sleds[0]); end
        tick(1);
        exp = {hb_led(cyc), 3'b001};
        total++; if (bus.sleds !== exp) begin bad++; $display("FAIL led0_up: got %b want %b", bus.sleds, exp); end
        // Glitch of DEBOUNCE-1 cycles on channel 1 must be absorbed.
        bus.link_up_raw = 2'b11;
        tick(3);
        bus.link_up_raw = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++; if (bus.link_stable !== 2'b01) begin bad++; $display("FAIL glitch edge %0d: got %b want 01", k, bus.link_stable); end
        end
        bus.link_up_raw = 2'b11;
        tick(6);
        total++; if (bus.link_stable !== 2'b11) begin bad++; $display("FAIL both_up: got %b want 11", bus.link_stable); end
        tick(1);
        exp = {hb_led(cyc), 3'b111};
        total++; if (bus.sleds !== exp) begin bad++; $display("FAIL leds_both_up: got %b want %b", bus.sleds, exp); end
    endtask

    task automatic test_activity();
        logic [3:0] exp;
        bus.rx_act = 2'b10;
        tick(1);
        bus.rx_act = 2'b00;
        // 20 cycles of blink on LED1, then steady on.
        for (int j = 1; j <= 24; j++) begin
            tick(1);
            exp = {hb_led(cyc), 1'b1, (j <= 20) ? blink_led(cyc) : 1'b1, 1'b1};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL stretch j=%0d: got %b want %b", j, bus.sleds, exp); end
        end
        // Activity on a down channel is ignored and leaves nothing behind.
        bus.link_up_raw = 2'b10;
        tick(6);
        total++; if (bus.link_stable !== 2'b10) begin bad++; $display("FAIL ch0_down: got %b want 10", bus.link_stable); end
        bus.tx_act = 2'b01;
        tick(1);
        bus.tx_act = 2'b00;
        tick(1);
        total++; if (bus.sleds[0] !== 1'b0) begin bad++; $display("FAIL act_on_down: got %b want 0", bus.sleds[0]); end
        bus.link_up_raw = 2'b11;
        tick(7);
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            exp = {hb_led(cyc), 3'b111};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL no_residual_act j=%0d: got %b want %b", j, bus.sleds, exp); end
        end
    endtask

    task automatic drop_link0();
        bus.link_up_raw = 2'b10;
        tick(7);
        bus.link_up_raw = 2'b11;
        tick(7);
    endtask

    task automatic test_drops();
        bus.drop_cnt_clr = 1'b1;
        tick(1);
        bus.drop_cnt_clr = 1'b0;
        total++; if (bus.link_drop_cnt !== 16'h0000) begin bad++; $display("FAIL clr: got %h want 0000", bus.link_drop_cnt); end
        repeat (3) drop_link0();
        total++; if (bus.link_drop_cnt !== 16'h0003) begin bad++; $display("FAIL drop3: got %h want 0003", bus.link_drop_cnt); end
        repeat (252) drop_link0();
        total++; if (bus.link_drop_cnt !== 16'h00FF) begin bad++; $display("FAIL drop255: got %h want 00ff", bus.link_drop_cnt); end
        repeat (48) drop_link0();
        total++; if (bus.link_drop_cnt !== 16'h00FF) begin bad++; $display("FAIL drop_sat: got %h want 00ff", bus.link_drop_cnt); end
        total++; if (bus.link_stable !== 2'b11) begin bad++; $display("FAIL drop_restore: got %b want 11", bus.link_stable); end
        bus.drop_cnt_clr = 1'b1;
        tick(1);
        bus.drop_cnt_clr = 1'b0;
        total++; if (bus.link_drop_cnt !== 16'h0000) begin bad++; $display("FAIL clr_sat: got %h want 0000", bus.link_drop_cnt); end
        // Clear lands on the same edge as the drop.
        bus.link_up_raw = 2'b10;
        tick(5);
        total++; if (bus.link_stable !== 2'b11) begin bad++; $display("FAIL pre_drop: got %b want 11", bus.link_stable); end
        bus.drop_cnt_clr = 1'b1;
        tick(1);
        bus.drop_cnt_clr = 1'b0;
        total++; if (bus.link_stable !== 2'b10) begin bad++; $display("FAIL coincident_stable: got %b want 10", bus.link_stable); end
        total++; if (bus.link_drop_cnt !== 16'h0001) begin bad++; $display("FAIL clr_and_drop: got %h want 0001", bus.link_drop_cnt); end
        bus.link_up_raw = 2'b11;
        tick(7);
    endtask

    task automatic test_mode1();
        logic [3:0] exp;
        bus.link_up_raw = 2'b01;
        tick(7);
        total++; if (bus.link_drop_cnt !== 16'h0101) begin bad++; $display("FAIL drop_ch1: got %h want 0101", bus.link_drop_cnt); end
        bus.led_mode = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            exp = {hb_led(cyc), 3'b100};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL mode1_down j=%0d: got %b want %b", j, bus.sleds, exp); end
        end
        bus.link_up_raw = 2'b11;
        tick(7);
        exp = {hb_led(cyc), 3'b101};
        total++; if (bus.sleds !== exp) begin bad++; $display("FAIL mode1_up: got %b want %b", bus.sleds, exp); end
        bus.rx_act = 2'b01;
        tick(1);
        bus.rx_act = 2'b00;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            exp = {hb_led(cyc), 1'b1, blink_led(cyc), 1'b1};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL mode1_act j=%0d: got %b want %b", j, bus.sleds, exp); end
        end
        bus.led_mode = 1'b0;
        tick(25);
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        logic [1:0] exp_st;
        bus.link_up_raw = 2'b10;
        tick(7);
        bus.rx_act = 2'b10;
        tick(1);
        bus.rx_act = 2'b00;
        // Channel 0 rising debounce and channel 1 stretch both in flight.
        bus.link_up_raw = 2'b11;
        tick(3);
        sys_reset = 1'b1;
        tick(1);
        total++; if (bus.sleds !== 4'b0000) begin bad++; $display("FAIL mid_reset_sleds: got %b want 0000", bus.sleds); end
        total++; if (bus.link_stable !== 2'b00) begin bad++; $display("FAIL mid_reset_stable: got %b want 00", bus.link_stable); end
        total++; if (bus.link_drop_cnt !== 16'h0000) begin bad++; $display("FAIL mid_reset_drop: got %h want 0000", bus.link_drop_cnt); end
        sys_reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_st = (k >= 6) ? 2'b11 : 2'b00;
            total++; if (bus.link_stable !== exp_st) begin bad++; $display("FAIL restart_debounce edge %0d: got %b want %b", k, bus.link_stable, exp_st); end
        end
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            exp = {hb_led(cyc), 3'b111};
            total++; if (bus.sleds !== exp) begin bad++; $display("FAIL post_reset_leds j=%0d: got %b want %b", j, bus.sleds, exp); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_debounce();
        test_activity();
        test_drops();
        test_mode1();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
